// File: rtl/mmp_iddmm_pkg.sv
// rtl/mmp_iddmm_pkg.sv - shared widths and record types for the IDDMM addend arbiter
// Purpose: operand/result width constants, the result-FIFO entry and the tag-stage record.
package mmp_iddmm_pkg;

    localparam int A_W  = 129;
    localparam int BC_W = 256;
    localparam int D_W  = 257;

    typedef struct packed {
        logic           id;
        logic [D_W-1:0] d;
    } rsp_ent_t;

    typedef struct packed {
        logic vld;
        logic id;
    } tag_t;

endpackage

// File: rtl/mmp_iddmm_addend_arb_if.sv
// rtl/mmp_iddmm_addend_arb_if.sv - bundle of requester, addend and response signals
// Purpose: groups every non-clock port of mmp_iddmm_addend_arb.
// Modports:
//   slave  - the arbiter side (accepts requests, drives add_*, presents responses)
//   master - the surrounding environment (requesters, addend, response consumer)
interface mmp_iddmm_addend_arb_if
    import mmp_iddmm_pkg::*;
();
    logic            req0_valid;
    logic            req0_ready;
    logic [A_W-1:0]  req0_a;
    logic [BC_W-1:0] req0_b;
    logic [BC_W-1:0] req0_c;
    logic            req1_valid;
    logic            req1_ready;
    logic [A_W-1:0]  req1_a;
    logic [BC_W-1:0] req1_b;
    logic [BC_W-1:0] req1_c;
    logic [A_W-1:0]  add_a;
    logic [BC_W-1:0] add_b;
    logic [BC_W-1:0] add_c;
    logic [D_W-1:0]  add_d;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [D_W-1:0]  rsp_d;
    logic            rsp_id;
    logic            busy;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_c,
        input  req1_valid, req1_a, req1_b, req1_c,
        input  add_d, rsp_ready,
        output req0_ready, req1_ready,
        output add_a, add_b, add_c,
        output rsp_valid, rsp_d, rsp_id, busy
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_c,
        output req1_valid, req1_a, req1_b, req1_c,
        output add_d, rsp_ready,
        input  req0_ready, req1_ready,
        input  add_a, add_b, add_c,
        input  rsp_valid, rsp_d, rsp_id, busy
    );

endinterface

// File: rtl/mmp_iddmm_rsp_fifo.sv
// rtl/mmp_iddmm_rsp_fifo.sv - synchronous FIFO with registered head
// Purpose: shift-register FIFO; entry 0 is always the head, so head_data comes straight from a flop.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   push, push_data     - write request and data (ignored when full unless popping)
//   pop                 - read request (ignored when empty)
//   head_data           - current head entry (0 after reset)
//   full, empty, count  - occupancy status
module mmp_iddmm_rsp_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic             do_pop;
    logic             do_push;
    logic [CW-1:0]    wr_idx;

    always_comb begin
        mem_d   = mem_q;
        do_pop  = pop && (count_q != '0);
        do_push = push && ((count_q != CW'(DEPTH)) || do_pop);
        // After a pop the tail slides down one slot, so the write lands one lower.
        wr_idx  = count_q - CW'(do_pop);
        if (do_pop) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                mem_d[i] = mem_q[i+1];
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (do_push && (CW'(i) == wr_idx)) begin
                mem_d[i] = push_data;
            end
        end
        count_d = count_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            count_q <= count_d;
        end
    end

    assign head_data = mem_q[0];
    assign empty     = (count_q == '0);
    assign full      = (count_q == CW'(DEPTH));
    assign count     = count_q;

endmodule

// File: rtl/mmp_iddmm_addend_arb.sv
// rtl/mmp_iddmm_addend_arb.sv - round-robin sharing of one d = a + b + c addend between two requesters
// Purpose: grants one operand triple per cycle, registers it onto add_*, tracks it through a
//          LATENCY+1 tag pipeline and queues {id, add_d} in a credit-protected result FIFO.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   bus        - slave modport: req0/req1 valid/ready/a/b/c, add_a/b/c/d, rsp valid/ready/d/id, busy
module mmp_iddmm_addend_arb
    import mmp_iddmm_pkg::*;
#(
    parameter int LATENCY    = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    mmp_iddmm_addend_arb_if.slave        bus
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);

    // Credit = FIFO slots not yet claimed by an in-flight or queued result.
    logic [CW-1:0]   credit_q, credit_d;
    logic            rr_q, rr_d;
    logic [A_W-1:0]  add_a_q, add_a_d;
    logic [BC_W-1:0] add_b_q, add_b_d;
    logic [BC_W-1:0] add_c_q, add_c_d;
    tag_t            tag_q [LATENCY+1];
    tag_t            tag_d [LATENCY+1];

    logic            gnt_vld;
    logic            gnt_id;
    logic            fifo_pop;
    logic            fifo_push;
    logic            fifo_full;
    logic            fifo_empty;
    logic [CW-1:0]   fifo_count;
    rsp_ent_t        push_ent;
    rsp_ent_t        head_ent;
    logic            tag_any;

    always_comb begin
        gnt_id = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            gnt_id = rr_q;
        end else if (bus.req1_valid) begin
            gnt_id = 1'b1;
        end
        gnt_vld = (credit_q != '0) && (bus.req0_valid || bus.req1_valid);
    end

    assign bus.req0_ready = gnt_vld && !gnt_id;
    assign bus.req1_ready = gnt_vld && gnt_id;

    assign fifo_pop  = !fifo_empty && bus.rsp_ready;
    // Credit already guarantees room; the pop term keeps a full-and-popping FIFO writable.
    assign fifo_push = tag_q[LATENCY].vld && (!fifo_full || fifo_pop);
    assign push_ent  = '{id: tag_q[LATENCY].id, d: bus.add_d};

    always_comb begin
        credit_d = credit_q + CW'(fifo_pop) - CW'(gnt_vld);
        rr_d     = gnt_vld ? !gnt_id : rr_q;
        add_a_d  = add_a_q;
        add_b_d  = add_b_q;
        add_c_d  = add_c_q;
        if (gnt_vld) begin
            add_a_d = gnt_id ? bus.req1_a : bus.req0_a;
            add_b_d = gnt_id ? bus.req1_b : bus.req0_b;
            add_c_d = gnt_id ? bus.req1_c : bus.req0_c;
        end
        tag_d[0] = '{vld: gnt_vld, id: gnt_id};
        for (int i = 1; i <= LATENCY; i++) begin
            tag_d[i] = tag_q[i-1];
        end
    end

    always_comb begin
        tag_any = 1'b0;
        for (int i = 0; i <= LATENCY; i++) begin
            tag_any = tag_any | tag_q[i].vld;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credit_q <= CW'(FIFO_DEPTH);
            rr_q     <= 1'b0;
            add_a_q  <= '0;
            add_b_q  <= '0;
            add_c_q  <= '0;
            for (int i = 0; i <= LATENCY; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            credit_q <= credit_d;
            rr_q     <= rr_d;
            add_a_q  <= add_a_d;
            add_b_q  <= add_b_d;
            add_c_q  <= add_c_d;
            tag_q    <= tag_d;
        end
    end

    mmp_iddmm_rsp_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(rsp_ent_t))
    ) u_rsp_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data (push_ent),
        .pop       (fifo_pop),
        .head_data (head_ent),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign bus.add_a     = add_a_q;
    assign bus.add_b     = add_b_q;
    assign bus.add_c     = add_c_q;
    assign bus.rsp_valid = !fifo_empty;
    assign bus.rsp_d     = head_ent.d;
    assign bus.rsp_id    = head_ent.id;
    assign bus.busy      = tag_any || (fifo_count != '0);

endmodule

// File: tb/tb_mmp_iddmm_addend_arb.sv
// tb/tb_mmp_iddmm_addend_arb.sv - self-checking bench, LATENCY=2 and LATENCY=0 instances side by side
module tb_mmp_iddmm_addend_arb;
    import mmp_iddmm_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic            r0v = 0, r1v = 0, rdy = 0;
    logic [A_W-1:0]  r0a = '0, r1a = '0;
    logic [BC_W-1:0] r0b = '0, r0c = '0, r1b = '0, r1c = '0;

    logic            d_rdy0 [2];
    logic            d_rdy1 [2];
    logic            d_rv   [2];
    logic            d_rid  [2];
    logic            d_busy [2];
    logic [D_W-1:0]  d_rd   [2];
    logic [A_W-1:0]  d_aa   [2];
    logic [BC_W-1:0] d_ab   [2];
    logic [BC_W-1:0] d_ac   [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int L = (g == 0) ? 2 : 0;
        mmp_iddmm_addend_arb_if bus ();
        logic [D_W-1:0] sum_w;

        assign bus.req0_valid = r0v;
        assign bus.req0_a     = r0a;
        assign bus.req0_b     = r0b;
        assign bus.req0_c     = r0c;
        assign bus.req1_valid = r1v;
        assign bus.req1_a     = r1a;
        assign bus.req1_b     = r1b;
        assign bus.req1_c     = r1c;
        assign bus.rsp_ready  = rdy;

        mmp_iddmm_addend_arb #(.LATENCY(L), .FIFO_DEPTH(4)) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus)
        );

        // Addend stand-in: d = a + b + c, delayed by L registers.
        assign sum_w = {128'b0, bus.add_a} + {1'b0, bus.add_b} + {1'b0, bus.add_c};
        if (L == 0) begin : g_comb
            assign bus.add_d = sum_w;
        end else begin : g_pipe
            logic [D_W-1:0] p [L];
            always @(posedge clk) begin
                p[0] <= sum_w;
                for (int i = 1; i < L; i++) p[i] <= p[i-1];
            end
            assign bus.add_d = p[L-1];
        end

        assign d_rdy0[g] = bus.req0_ready;
        assign d_rdy1[g] = bus.req1_ready;
        assign d_rv[g]   = bus.rsp_valid;
        assign d_rid[g]  = bus.rsp_id;
        assign d_busy[g] = bus.busy;
        assign d_rd[g]   = bus.rsp_d;
        assign d_aa[g]   = bus.add_a;
        assign d_ab[g]   = bus.add_b;
        assign d_ac[g]   = bus.add_c;
    end

    // Model: one ordered list of issued ops per instance; an op is visible in the
    // response FIFO once LAT+1 edges have passed since its issue edge.
    typedef struct {
        longint         cyc;
        logic           id;
        logic [D_W-1:0] d;
    } ent_t;

    ent_t            mq [2][$];
    int              rr [2];
    int              lat [2];
    logic [A_W-1:0]  ea [2];
    logic [BC_W-1:0] eb [2];
    logic [BC_W-1:0] ec [2];
    int              acc_cnt [2];
    int              acc_ids0 [$];
    longint          cyc = 0;
    int              n_chk = 0;
    int              n_fail = 0;

    task automatic chk(input string nm, input int k, input logic [D_W-1:0] act, input logic [D_W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[lat%0d]: got %0h expected %0h", nm, lat[k], act, exp);
        end
    endtask

    function automatic logic head_vis(input int k);
        if (mq[k].size() == 0) return 1'b0;
        return cyc >= mq[k][0].cyc + longint'(lat[k]) + 1;
    endfunction

    function automatic logic [D_W-1:0] ref_sum(input logic [A_W-1:0] a, input logic [BC_W-1:0] b, input logic [BC_W-1:0] c);
        return {128'b0, a} + {1'b0, b} + {1'b0, c};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mq[k].delete();
            rr[k] = 0;
            ea[k] = '0;
            eb[k] = '0;
            ec[k] = '0;
        end
    endtask

    // Called just after a falling edge with inputs already set.
    task automatic step();
        int   g [2];
        logic pop [2];
        int   credit;
        ent_t e;
        #1;
        for (int k = 0; k < 2; k++) begin
            credit = 4 - mq[k].size();
            g[k] = -1;
            if (credit != 0) begin
                if (r0v && r1v) g[k] = rr[k];
                else if (r0v)   g[k] = 0;
                else if (r1v)   g[k] = 1;
            end
            chk("req0_ready", k, D_W'(d_rdy0[k]), D_W'(g[k] == 0));
            chk("req1_ready", k, D_W'(d_rdy1[k]), D_W'(g[k] == 1));
            pop[k] = head_vis(k) && rdy;
        end
        @(posedge clk);
        cyc++;
        for (int k = 0; k < 2; k++) begin
            if (pop[k]) void'(mq[k].pop_front());
            if (g[k] >= 0) begin
                ea[k] = (g[k] == 1) ? r1a : r0a;
                eb[k] = (g[k] == 1) ? r1b : r0b;
                ec[k] = (g[k] == 1) ? r1c : r0c;
                e.cyc = cyc;
                e.id  = (g[k] == 1);
                e.d   = ref_sum(ea[k], eb[k], ec[k]);
                mq[k].push_back(e);
                rr[k] = 1 - g[k];
                acc_cnt[k]++;
                if (k == 0) acc_ids0.push_back(g[k]);
            end
        end
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("rsp_valid", k, D_W'(d_rv[k]), D_W'(head_vis(k)));
            if (head_vis(k)) begin
                chk("rsp_d", k, d_rd[k], mq[k][0].d);
                chk("rsp_id", k, D_W'(d_rid[k]), D_W'(mq[k][0].id));
            end
            chk("busy", k, D_W'(d_busy[k]), D_W'(mq[k].size() != 0));
            chk("add_a", k, D_W'(d_aa[k]), D_W'(ea[k]));
            chk("add_b", k, D_W'(d_ab[k]), D_W'(eb[k]));
            chk("add_c", k, D_W'(d_ac[k]), D_W'(ec[k]));
        end
    endtask

    function automatic logic [255:0] rnd256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    task automatic rand_ops();
        logic [255:0] t;
        t = rnd256(); r0a = t[A_W-1:0];
        t = rnd256(); r1a = t[A_W-1:0];
        r0b = rnd256(); r0c = rnd256();
        r1b = rnd256(); r1c = rnd256();
    endtask

    task automatic drain(input int n);
        r0v = 0; r1v = 0; rdy = 1;
        repeat (n) step();
    endtask

    // Issue one op and check the literal response and its latency on both instances.
    task automatic single_op(input logic id, input logic [A_W-1:0] a, input logic [BC_W-1:0] b,
                             input logic [BC_W-1:0] c, input logic [D_W-1:0] exp_d);
        int first [2];
        logic [D_W-1:0] got_d [2];
        logic got_id [2];
        rdy = 1;
        r0v = !id; r1v = id;
        r0a = a; r0b = b; r0c = c;
        r1a = a; r1b = b; r1c = c;
        step();
        r0v = 0; r1v = 0;
        first[0] = -1; first[1] = -1;
        for (int i = 1; i <= 8; i++) begin
            step();
            for (int k = 0; k < 2; k++) begin
                if (d_rv[k] && first[k] < 0) begin
                    first[k] = i;
                    got_d[k] = d_rd[k];
                    got_id[k] = d_rid[k];
                end
            end
        end
        // Instance 0 has LATENCY=2 (3 cycles), instance 1 LATENCY=0 (1 cycle).
        chk("lit_latency", 0, D_W'(first[0]), D_W'(3));
        chk("lit_latency", 1, D_W'(first[1]), D_W'(1));
        for (int k = 0; k < 2; k++) begin
            if (first[k] >= 0) begin
                chk("lit_rsp_d", k, got_d[k], exp_d);
                chk("lit_rsp_id", k, D_W'(got_id[k]), D_W'(id));
            end
        end
    endtask

    logic [D_W-1:0] wrap_exp;
    int base [2];

    initial begin
        lat[0] = 2; lat[1] = 0;
        acc_cnt[0] = 0; acc_cnt[1] = 0;
        model_reset();
        repeat (2) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("rst_rsp_valid", k, D_W'(d_rv[k]), '0);
            chk("rst_rsp_d", k, d_rd[k], '0);
            chk("rst_rsp_id", k, D_W'(d_rid[k]), '0);
            chk("rst_busy", k, D_W'(d_busy[k]), '0);
            chk("rst_add_a", k, D_W'(d_aa[k]), '0);
        end
        rst_n = 1;

        // Single op on requester 0: 1+2+3.
        single_op(1'b0, A_W'(1), BC_W'(2), BC_W'(3), D_W'(6));

        // Overflow wrap on requester 1: all-ones operands give 2^129 - 3.
        wrap_exp = (D_W'(1) << 129) - D_W'(3);
        single_op(1'b1, {A_W{1'b1}}, {BC_W{1'b1}}, {BC_W{1'b1}}, wrap_exp);

        // Contention: grants must alternate starting with requester 0.
        drain(6);
        acc_ids0.delete();
        r0v = 1; r1v = 1; rdy = 1;
        repeat (8) begin rand_ops(); step(); end
        chk("lit_contention_accepts", 0, D_W'(acc_ids0.size() >= 6), D_W'(1));
        for (int i = 0; i < acc_ids0.size(); i++) begin
            chk("lit_contention_order", 0, D_W'(acc_ids0[i]), D_W'(i % 2));
        end
        drain(8);

        // Backpressure: exactly 4 accepts, then one pop buys exactly one more.
        base[0] = acc_cnt[0]; base[1] = acc_cnt[1];
        r0v = 1; r1v = 1; rdy = 0;
        repeat (10) begin rand_ops(); step(); end
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("lit_bp_accepts", k, D_W'(acc_cnt[k] - base[k]), D_W'(4));
            chk("lit_bp_ready0", k, D_W'(d_rdy0[k]), '0);
            chk("lit_bp_ready1", k, D_W'(d_rdy1[k]), '0);
            base[k] = acc_cnt[k];
        end
        @(negedge clk);
        rdy = 1; rand_ops(); step();
        rdy = 0;
        repeat (5) begin rand_ops(); step(); end
        for (int k = 0; k < 2; k++) begin
            chk("lit_bp_one_more", k, D_W'(acc_cnt[k] - base[k]), D_W'(1));
        end
        drain(10);

        // Reset with work in flight and queued.
        r0v = 1; r1v = 1; rdy = 0;
        repeat (5) begin rand_ops(); step(); end
        r0v = 0; r1v = 0;
        rst_n = 0;
        #1;
        model_reset();
        for (int k = 0; k < 2; k++) begin
            chk("midrst_rsp_valid", k, D_W'(d_rv[k]), '0);
            chk("midrst_busy", k, D_W'(d_busy[k]), '0);
            chk("midrst_rsp_d", k, d_rd[k], '0);
        end
        @(negedge clk);
        rst_n = 1;
        drain(3);
        single_op(1'b0, A_W'(5), BC_W'(6), BC_W'(7), D_W'(18));
        drain(4);
        base[0] = acc_cnt[0]; base[1] = acc_cnt[1];
        r0v = 1; r1v = 1; rdy = 0;
        repeat (8) begin rand_ops(); step(); end
        for (int k = 0; k < 2; k++) begin
            chk("lit_credit_restored", k, D_W'(acc_cnt[k] - base[k]), D_W'(4));
        end
        drain(10);

        // Random traffic with random backpressure.
        repeat (20000) begin
            rand_ops();
            r0v = ($urandom_range(0, 3) != 0);
            r1v = ($urandom_range(0, 3) != 0);
            rdy = ($urandom_range(0, 3) != 0);
            step();
        end
        drain(12);
        for (int k = 0; k < 2; k++) begin
            chk("final_idle", k, D_W'(d_busy[k]), '0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
